regfile_writeback_queue: RTL

- Write-side companion to RegFile: buffers register write-backs from the datapath and issues them to RegFile's WriteReg/WriteData/RegWrite port, one per cycle.
- Provides read-after-write forwarding for RegFile's two read ports while writes are still pending.
- Sits between the datapath write-back stage and RegFile.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wbq_match.sv | 32 +++
 rtl/regfile_writeback_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;

  // Register 0 reads as constant zero, so writes to it are dropped.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // One pending write-back. The register field cannot be called "reg" (keyword).
  typedef struct packed {
    logic [ADDR_W-1:0] regnum;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Forwarding lookup for the write-back queue: reports whether any valid entry
// targets the lookup register and returns the data of the youngest such entry.
module wbq_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      rd_ptr,
  input  logic [ADDR_W-1:0]     lookup,
  output logic                  hit,
  output logic [DATA_W-1:0]     hit_data
);

  // Walk entries oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid[idx] && (lookup != ZERO_REG) && (entries[idx].regnum == lookup)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of RegFile: buffers write-backs in a circular FIFO
// and issues one per cycle to the RegFile write port.
// Optional feature macro WBQ_FORWARD_EN: read-after-write forwarding for the two
// RegFile read ports from pending entries. Without it Hit/HitData are tied to 0.
// DATA_W/ADDR_W must match the regfile_pkg constants (the entry type uses them).
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       InValid,
  input  logic [ADDR_W-1:0]          InReg,
  input  logic [DATA_W-1:0]          InData,
  output logic                       InReady,
  input  logic                       Stall,
  output logic [ADDR_W-1:0]          WriteReg,
  output logic [DATA_W-1:0]          WriteData,
  output logic                       RegWrite,
  input  logic [ADDR_W-1:0]          LookupReg1,
  input  logic [ADDR_W-1:0]          LookupReg2,
  output logic                       Hit1,
  output logic [DATA_W-1:0]          HitData1,
  output logic                       Hit2,
  output logic [DATA_W-1:0]          HitData2,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t [DEPTH-1:0] entry_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  // Handshake, issue and next-state bookkeeping.
  always_comb begin
    InReady = (count_q < FULL_CNT);
    push    = InValid && InReady && (InReg != ZERO_REG);
    pop     = (count_q != '0) && !Stall;

    RegWrite  = pop;
    WriteReg  = '0;
    WriteData = '0;
    if (count_q != '0) begin
      WriteReg  = entry_q[rd_ptr_q].regnum;
      WriteData = entry_q[rd_ptr_q].data;
    end

    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and valid mask; reset discards everything pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage needs no reset: contents are only observed through valid/count.
  always_ff @(posedge clock) begin
    if (push) begin
      entry_q[wr_ptr_q] <= '{regnum: InReg, data: InData};
    end
  end

  assign Count = count_q;

`ifdef WBQ_FORWARD_EN
  wbq_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match1 (
    .entries  (entry_q),
    .valid    (valid_q),
    .rd_ptr   (rd_ptr_q),
    .lookup   (LookupReg1),
    .hit      (Hit1),
    .hit_data (HitData1)
  );

  wbq_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match2 (
    .entries  (entry_q),
    .valid    (valid_q),
    .rd_ptr   (rd_ptr_q),
    .lookup   (LookupReg2),
    .hit      (Hit2),
    .hit_data (HitData2)
  );
`else
  // Datapath must stall reads while Count != 0 in this build.
  logic unused_fwd;
  assign unused_fwd = ^{valid_q, LookupReg1, LookupReg2};
  assign Hit1     = 1'b0;
  assign HitData1 = '0;
  assign Hit2     = 1'b0;
  assign HitData2 = '0;
`endif

endmodule
